bch_31_decoder: RTL and testbench
=================================

BCH_31_DECODER -- requirements
Module: bch_31_decoder

Interface
REQ-001 The block SHALL have exactly one clock, clk, and a synchronous active-high reset, rst, sampled on the rising edge of clk.
REQ-002 Port list, in order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  codeword offered
- in_ready  out  1  decoder can accept a codeword
- codeword  in  31  received word; bit i is the coefficient of x^i; message in [30:10], parity in [9:0]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- msg  out  21  decoded message, corrected bits [30:10]
- err_count  out  2  number of bits corrected: 0, 1 or 2
- uncorrectable  out  1  error pattern detected but not correctable
REQ-003 Code parameters SHALL be fixed:
- GF(32) with primitive polynomial x^5+x^2+1, alpha as its root.
- Generator polynomial x^10+x^9+x^8+x^6+x^5+x^3+1.
- Double-error correcting (t=2).

Function
REQ-004 The FSM SHALL have states IDLE, SYND, SOLVE, CHIEN and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE. An input handshake (in_valid and in_ready) in cycle T SHALL latch codeword and move to SYND.
REQ-006 SYND SHALL occupy cycles T+1..T+31.
- Syndromes are computed serially by Horner's rule, bit 30 first.
- S1 = r(alpha) and S3 = r(alpha^3), each 5 bits.
- A 5-bit down-counter indexes the bit; the state exits when it reaches 0.
REQ-007 SOLVE SHALL occupy cycle T+32 and classify the word as follows:
- S1=0 and S3=0: no error.
- S1!=0 and S3=S1^3: single error; sigma(x) = 1 + S1*x.
- S1!=0 and S3!=S1^3: double error; sigma(x) = 1 + S1*x + ((S3+S1^3)/S1)*x^2. The GF inverse is taken from a 31-entry table or an equivalent combinational inverse.
- S1=0 and S3!=0: uncorrectable.
REQ-008 CHIEN SHALL occupy cycles T+33..T+63.
- The cycle for position i (i = 0..30) evaluates sigma(alpha^-i).
- A zero value flips bit i of the latched word and increments the root count.
- Multiplier registers are updated by constant multiplication each cycle.
REQ-009 Entering DONE at T+64, the block SHALL register results and assert out_valid, giving a fixed latency of 64 cycles from input handshake to out_valid for every input class.
REQ-010 The root count SHALL be checked against the degree of sigma in DONE.
- If they match, uncorrectable=0, err_count equals the degree, and msg is the corrected bits [30:10].
- If they differ, or for the REQ-007 uncorrectable case, uncorrectable=1, err_count=0, and msg is the raw received bits [30:10] with no flips applied.
REQ-011 msg, err_count and uncorrectable SHALL stay stable while out_valid=1 and out_ready=0.
REQ-012 An output handshake (out_valid and out_ready) SHALL return the FSM to IDLE, deassert out_valid and assert in_ready in the next cycle. The block does not overlap input and output transactions.
REQ-013 in_valid SHALL be ignored outside IDLE, and codeword changes after the input handshake SHALL have no effect on the result.
REQ-014 All outputs SHALL be driven from registers.

Reset
REQ-015 When rst=1 at a clock edge, the following SHALL hold from the next cycle:
- FSM in IDLE; in_ready=1; out_valid=0.
- msg=0, err_count=0, uncorrectable=0.
- Syndrome, sigma, counter and latched-word registers cleared.
REQ-016 Reset asserted in any state, including mid-SYND, mid-CHIEN or DONE with out_ready=0, SHALL abort the transaction with no output handshake and take effect at that edge.
REQ-017 Reset SHALL take priority over the in_valid and out_ready handshakes in the same cycle.

Verification
REQ-018 Codeword 31'h00000000 with out_ready=1 -> out_valid exactly 64 cycles after the handshake, msg=21'h000000, err_count=0, uncorrectable=0.
REQ-019 Codeword 31'h00100769 (valid word 31'h00000769 with bit 20 flipped) -> msg=21'h000001, err_count=1, uncorrectable=0.
REQ-020 Codeword 31'h3FFFFFFE (valid all-ones word with bits 30 and 0 flipped) -> msg=21'h1FFFFF, err_count=2, uncorrectable=0.
REQ-021 Exhaustive single- and double-bit error patterns on 31'h00000769 -> every case yields msg=21'h000001 and the correct err_count. Random 3-error patterns -> results match a bit-accurate reference model.
REQ-022 Backpressure: codeword 31'h00000769 with out_ready held 0 for 10 cycles after out_valid -> outputs constant, in_ready=0 and in_valid ignored throughout. out_ready=1 -> in_ready=1 in the next cycle.
REQ-023 Reset mid-CHIEN: rst pulsed at T+40 -> next cycle in_ready=1, out_valid=0, msg=0. A subsequent codeword 31'h00000000 decodes per REQ-018.

Source files
------------

// File: rtl/bch_31_decoder.sv
// Serial BCH(31,21) double-error-correcting decoder: Horner syndromes, Peterson
// solve for sigma, Chien search. Fixed 64-cycle latency from accept to result.
module bch_31_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [30:0] codeword,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [20:0] msg,
   output logic [1:0]  err_count,
   output logic        uncorrectable
);
   typedef enum logic [2:0] {IDLE, SYND, SOLVE, CHIEN, DONE} state_t;

   // GF(32) constants for x^5+x^2+1: alpha, alpha^3, alpha^-1, alpha^-2
   localparam logic [4:0] A1    = 5'b00010;
   localparam logic [4:0] A3    = 5'b01000;
   localparam logic [4:0] AINV1 = 5'b10010;
   localparam logic [4:0] AINV2 = 5'b01001;

   function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
      logic [4:0] p;
      logic [4:0] t;
      p = 5'd0;
      t = a;
      for (int k = 0; k < 5; k++) begin
         if (b[k]) p = p ^ t;
         t = {t[3:0], 1'b0} ^ (t[4] ? 5'b00101 : 5'b00000);
      end
      return p;
   endfunction

   // x^-1 = x^30 = x^16 * x^8 * x^4 * x^2
   function automatic logic [4:0] gf_inv(input logic [4:0] x);
      logic [4:0] x2, x4, x8, x16;
      x2  = gf_mul(x, x);
      x4  = gf_mul(x2, x2);
      x8  = gf_mul(x4, x4);
      x16 = gf_mul(x8, x8);
      return gf_mul(gf_mul(x16, x8), gf_mul(x4, x2));
   endfunction

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [30:0] word_q, word_d;
   logic [20:0] raw_q, raw_d;
   logic [4:0]  s1_q, s1_d, s3_q, s3_d;
   logic [4:0]  m1_q, m1_d, m2_q, m2_d;
   logic [1:0]  deg_q, deg_d, roots_q, roots_d;
   logic        bad_q, bad_d;
   logic [20:0] msg_q, msg_d;
   logic [1:0]  errc_q, errc_d;
   logic        uncor_q, uncor_d;
   logic        out_valid_q, out_valid_d;
   logic        in_ready_q, in_ready_d;

   logic [4:0]  cube;
   logic [4:0]  eval;
   logic        flip;
   logic [30:0] word_nx;
   logic [1:0]  roots_nx;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      raw_d       = raw_q;
      s1_d        = s1_q;
      s3_d        = s3_q;
      m1_d        = m1_q;
      m2_d        = m2_q;
      deg_d       = deg_q;
      roots_d     = roots_q;
      bad_d       = bad_q;
      msg_d       = msg_q;
      errc_d      = errc_q;
      uncor_d     = uncor_q;
      out_valid_d = out_valid_q;
      cube        = gf_mul(s1_q, gf_mul(s1_q, s1_q));
      eval        = 5'd1 ^ m1_q ^ m2_q;
      flip        = (eval == 5'd0);
      word_nx     = word_q ^ (flip ? (31'd1 << cnt_q) : 31'd0);
      roots_nx    = roots_q + {1'b0, flip};

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d  = codeword;
               raw_d   = codeword[30:10];
               s1_d    = 5'd0;
               s3_d    = 5'd0;
               cnt_d   = 5'd30;
               state_d = SYND;
            end
         end
         SYND: begin
            s1_d = gf_mul(s1_q, A1) ^ {4'd0, word_q[cnt_q]};
            s3_d = gf_mul(s3_q, A3) ^ {4'd0, word_q[cnt_q]};
            if (cnt_q == 5'd0) state_d = SOLVE;
            else               cnt_d   = cnt_q - 5'd1;
         end
         SOLVE: begin
            m1_d  = 5'd0;
            m2_d  = 5'd0;
            deg_d = 2'd0;
            bad_d = 1'b0;
            if (s1_q == 5'd0) begin
               bad_d = (s3_q != 5'd0);
            end else if (s3_q == cube) begin
               m1_d  = s1_q;
               deg_d = 2'd1;
            end else begin
               m1_d  = s1_q;
               m2_d  = gf_mul(s3_q ^ cube, gf_inv(s1_q));
               deg_d = 2'd2;
            end
            roots_d = 2'd0;
            cnt_d   = 5'd0;
            state_d = CHIEN;
         end
         CHIEN: begin
            // Position cnt_q tests sigma(alpha^-cnt_q); multipliers step by alpha^-1, alpha^-2
            word_d  = word_nx;
            roots_d = roots_nx;
            m1_d    = gf_mul(m1_q, AINV1);
            m2_d    = gf_mul(m2_q, AINV2);
            if (cnt_q == 5'd30) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               if (bad_q || (roots_nx != deg_q)) begin
                  msg_d   = raw_q;
                  errc_d  = 2'd0;
                  uncor_d = 1'b1;
               end else begin
                  msg_d   = word_nx[30:10];
                  errc_d  = deg_q;
                  uncor_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 5'd0;
         word_q      <= 31'd0;
         raw_q       <= 21'd0;
         s1_q        <= 5'd0;
         s3_q        <= 5'd0;
         m1_q        <= 5'd0;
         m2_q        <= 5'd0;
         deg_q       <= 2'd0;
         roots_q     <= 2'd0;
         bad_q       <= 1'b0;
         msg_q       <= 21'd0;
         errc_q      <= 2'd0;
         uncor_q     <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         raw_q       <= raw_d;
         s1_q        <= s1_d;
         s3_q        <= s3_d;
         m1_q        <= m1_d;
         m2_q        <= m2_d;
         deg_q       <= deg_d;
         roots_q     <= roots_d;
         bad_q       <= bad_d;
         msg_q       <= msg_d;
         errc_q      <= errc_d;
         uncor_q     <= uncor_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign msg           = msg_q;
   assign err_count     = errc_q;
   assign uncorrectable = uncor_q;
endmodule

// File: tb/tb_bch_31_decoder.sv
// Scoreboard bench for bch_31_decoder; the reference decoder works on remainders
// modulo g(x) and a brute-force search over all error patterns of weight <= 2.
module tb_bch_31_decoder;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [30:0] codeword;
   logic        out_valid;
   logic        out_ready;
   logic [20:0] msg;
   logic [1:0]  err_count;
   logic        uncorrectable;

   bch_31_decoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .codeword(codeword), .out_valid(out_valid), .out_ready(out_ready),
      .msg(msg), .err_count(err_count), .uncorrectable(uncorrectable)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   bit          seen     = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [20:0] msg;
      logic [1:0]  ec;
      logic        unc;
      int unsigned hs;
   } exp_t;
   exp_t q[$];

   logic [9:0] rem_tab[31];   // x^i mod g(x)

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=%h required=%h @cyc %0d", name, act, want, cyc);
      end
   endtask

   function automatic logic [9:0] synd(input logic [30:0] w);
      logic [9:0] s = 10'd0;
      for (int i = 0; i < 31; i++) if (w[i]) s = s ^ rem_tab[i];
      return s;
   endfunction

   // Bounded-distance decode: nearest codeword within distance 2, else flag.
   function automatic exp_t model(input logic [30:0] w);
      exp_t       e;
      logic [9:0] s;
      logic [30:0] one;
      bit         found;
      one   = 31'd1;
      s     = synd(w);
      e.msg = w[30:10];
      e.ec  = 2'd0;
      e.unc = 1'b1;
      e.hs  = 0;
      found = 1'b0;
      if (s == 10'd0) begin
         e.unc = 1'b0;
         found = 1'b1;
      end
      for (int i = 0; i < 31 && !found; i++) begin
         if (rem_tab[i] == s) begin
            e.msg = (w ^ (one << i)) >> 10;
            e.ec = 2'd1; e.unc = 1'b0; found = 1'b1;
         end
      end
      for (int i = 0; i < 31 && !found; i++) begin
         for (int j = i + 1; j < 31 && !found; j++) begin
            if ((rem_tab[i] ^ rem_tab[j]) == s) begin
               e.msg = (w ^ (one << i) ^ (one << j)) >> 10;
               e.ec = 2'd2; e.unc = 1'b0; found = 1'b1;
            end
         end
      end
      return e;
   endfunction

   function automatic logic [30:0] encode(input logic [20:0] m);
      logic [30:0] w;
      w = {m, 10'd0};
      return w | {21'd0, synd(w)};
   endfunction

   // Monitor: compare on the first cycle of each result presentation
   always @(negedge clk) begin
      exp_t e;
      if (rst || !out_valid) begin
         seen = 1'b0;
      end else if (!seen) begin
         seen = 1'b1;
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual msg=%h required=no output", msg);
         end else begin
            e = q.pop_front();
            check("msg", {11'd0, msg}, {11'd0, e.msg});
            check("err_count", {30'd0, err_count}, {30'd0, e.ec});
            check("uncorrectable", {31'd0, uncorrectable}, {31'd0, e.unc});
            check("latency", cyc - e.hs, 32'd64);
         end
      end
   end

   task automatic send(input logic [30:0] cw, input bit expect_out);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      codeword = cw;
      if (expect_out) begin
         e    = model(cw);
         e.hs = cyc;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      codeword = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", q.size(), 32'd0);
      q.delete();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [30:0] one;
      logic [10:0] r;
      logic [30:0] w;
      one = 31'd1;
      r   = 11'd1;
      for (int i = 0; i < 31; i++) begin
         rem_tab[i] = r[9:0];
         r = {r[9:0], 1'b0};
         if (r[10]) r = r ^ 11'h769;
      end

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; codeword = 31'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_msg", {11'd0, msg}, 32'd0);
      check("rst_err_count", {30'd0, err_count}, 32'd0);
      check("rst_uncorrectable", {31'd0, uncorrectable}, 32'd0);
      rst = 1'b0;

      send(31'h00000000, 1'b1);
      send(31'h00100769, 1'b1);
      send(31'h3FFFFFFE, 1'b1);
      drain();

      for (int i = 0; i < 31; i++) send(31'h00000769 ^ (one << i), 1'b1);
      for (int i = 0; i < 31; i++)
         for (int j = i + 1; j < 31; j++)
            send(31'h00000769 ^ (one << i) ^ (one << j), 1'b1);

      for (int k = 0; k < 60; k++) begin
         int a, b, c;
         a = $urandom_range(0, 30);
         do b = $urandom_range(0, 30); while (b == a);
         do c = $urandom_range(0, 30); while (c == a || c == b);
         send(31'h00000769 ^ (one << a) ^ (one << b) ^ (one << c), 1'b1);
      end
      for (int k = 0; k < 60; k++) begin
         w = encode(21'($urandom));
         for (int e = 0; e < int'(k % 4); e++) w = w ^ (one << $urandom_range(0, 30));
         send(w, 1'b1);
      end
      for (int k = 0; k < 30; k++) send(31'($urandom), 1'b1);
      drain();

      // Backpressure: result held, in_valid ignored, release returns to idle
      out_ready = 1'b0;
      send(31'h00000769, 1'b1);
      drain();
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         codeword = $urandom;
         @(negedge clk);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_msg", {11'd0, msg}, 32'd1);
         check("bp_err_count", {30'd0, err_count}, 32'd0);
         check("bp_uncorrectable", {31'd0, uncorrectable}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

      // Reset mid-Chien aborts the transaction
      send(31'h3FFFFFFE, 1'b0);
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_msg", {11'd0, msg}, 32'd0);
      repeat (70) @(negedge clk);
      send(31'h00000000, 1'b1);
      drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
